// File: rtl/prbs_checker_16lane.sv
// prbs_checker_16lane
// Receive-side checker for 16 independent PRBS lanes carried one bit per lane
// in each valid deserialized word. Each lane self-seeds from the incoming
// stream, then a shared FSM verifies the stream (CHECK), declares lock, counts
// bit errors while LOCKED and reseeds after a run of errored words.
// Optional feature: define PRBS_CHK_LANE_STICKY_EN to build per-lane sticky
// error flags; otherwise lane_err_sticky is tied to zero.
module prbs_checker_16lane #(
    parameter int                N_PRBS   = 32,
    parameter logic [N_PRBS-1:0] EQN      = 32'h0010_0002,
    parameter int                LOCK_CNT = 8,
    parameter int                LOSS_CNT = 4,
    parameter int                ERR_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [15:0]      din,
    input  logic             din_valid,
    input  logic             clr,
    output logic [1:0]       state,
    output logic             locked,
    output logic             err_word,
    output logic [15:0]      lane_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [15:0]      lane_err_sticky
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEED   = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam int SEED_W = $clog2(N_PRBS + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(LOSS_CNT + 1);

    localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(N_PRBS - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_CNT - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    state_t              state_reg;
    logic                locked_reg;
    logic                err_word_reg;
    logic [15:0]         lane_err_reg;
    logic [ERR_W-1:0]    err_cnt_reg;
    logic [SEED_W-1:0]   seed_cnt_reg;
    logic [GOOD_W-1:0]   good_cnt_reg;
    logic [BAD_W-1:0]    bad_cnt_reg;
    logic [N_PRBS-1:0]   hist_reg [16];

    logic [15:0]         pred;
    logic [15:0]         e;
    logic [4:0]          err_pop;
    logic [ERR_W+4:0]    err_sum;
    logic [ERR_W-1:0]    err_cnt_next;
    logic                word_active;

    // A word is only consumed when enabled and valid.
    assign word_active = en && din_valid;

    // Per-lane prediction from the lane history and the resulting error bit.
    for (genvar gi = 0; gi < 16; gi++) begin : g_lane
        assign pred[gi] = ^(hist_reg[gi] & EQN);
        assign e[gi]    = din[gi] ^ pred[gi];
    end

    // Number of lanes in error for this word.
    always_comb begin
        err_pop = '0;
        for (int i = 0; i < 16; i++) begin
            err_pop = err_pop + 5'(e[i]);
        end
    end

    // Saturating accumulation: widened sum so no overflow can wrap.
    assign err_sum      = {5'b0, err_cnt_reg} + {{ERR_W{1'b0}}, err_pop};
    assign err_cnt_next = (err_sum[ERR_W+4:ERR_W] != '0) ? ERR_MAX : err_sum[ERR_W-1:0];

    // Lane history: seeded/self-synchronised from din, free-running on prediction when locked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 16; l++) begin
                hist_reg[l] <= '0;
            end
        end else if (word_active) begin
            for (int l = 0; l < 16; l++) begin
                if (state_reg == SEED || state_reg == CHECK) begin
                    hist_reg[l] <= {hist_reg[l][N_PRBS-2:0], din[l]};
                end else if (state_reg == LOCKED) begin
                    hist_reg[l] <= {hist_reg[l][N_PRBS-2:0], pred[l]};
                end
            end
        end
    end

    // FSM with its counters, registered status and the per-word error report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            locked_reg   <= 1'b0;
            err_word_reg <= 1'b0;
            lane_err_reg <= '0;
            seed_cnt_reg <= '0;
            good_cnt_reg <= '0;
            bad_cnt_reg  <= '0;
        end else begin
            err_word_reg <= 1'b0;
            lane_err_reg <= '0;
            if (!en) begin
                state_reg    <= IDLE;
                locked_reg   <= 1'b0;
                seed_cnt_reg <= '0;
                good_cnt_reg <= '0;
                bad_cnt_reg  <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg    <= SEED;
                        seed_cnt_reg <= '0;
                    end
                    SEED: begin
                        if (din_valid) begin
                            if (seed_cnt_reg == SEED_LAST) begin
                                state_reg    <= CHECK;
                                seed_cnt_reg <= '0;
                                good_cnt_reg <= '0;
                            end else begin
                                seed_cnt_reg <= seed_cnt_reg + 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        if (din_valid) begin
                            if (|e) begin
                                good_cnt_reg <= '0;
                            end else if (good_cnt_reg == GOOD_LAST) begin
                                state_reg    <= LOCKED;
                                locked_reg   <= 1'b1;
                                good_cnt_reg <= '0;
                                bad_cnt_reg  <= '0;
                            end else begin
                                good_cnt_reg <= good_cnt_reg + 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (din_valid) begin
                            err_word_reg <= |e;
                            lane_err_reg <= e;
                            if (|e) begin
                                if (bad_cnt_reg == BAD_LAST) begin
                                    state_reg    <= SEED;
                                    locked_reg   <= 1'b0;
                                    seed_cnt_reg <= '0;
                                    bad_cnt_reg  <= '0;
                                end else begin
                                    bad_cnt_reg <= bad_cnt_reg + 1'b1;
                                end
                            end else begin
                                bad_cnt_reg <= '0;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // Error counter: clr wins over a same-cycle increment; only LOCKED words count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (clr) begin
            err_cnt_reg <= '0;
        end else if (word_active && state_reg == LOCKED) begin
            err_cnt_reg <= err_cnt_next;
        end
    end

`ifdef PRBS_CHK_LANE_STICKY_EN
    logic [15:0] sticky_reg;

    // Sticky per-lane flags, set by LOCKED errors and cleared only by clr or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg <= '0;
        end else if (clr) begin
            sticky_reg <= '0;
        end else if (word_active && state_reg == LOCKED) begin
            sticky_reg <= sticky_reg | e;
        end
    end

    assign lane_err_sticky = sticky_reg;
`else
    assign lane_err_sticky = 16'h0000;
`endif

    assign state    = state_reg;
    assign locked   = locked_reg;
    assign err_word = err_word_reg;
    assign lane_err = lane_err_reg;
    assign err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_prbs_checker_16lane.sv
// Directed bench for prbs_checker_16lane: 16 PRBS generators drive the
// checker; a second instance with a 4-bit error counter shares the stimulus
// to exercise saturation.
module tb_prbs_checker_16lane;

    localparam logic [31:0] EQN = 32'h0010_0002;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] din;
    logic        din_valid;
    logic        clr;

    logic [1:0]  state, state4;
    logic        locked, locked4;
    logic        err_word, err_word4;
    logic [15:0] lane_err, lane_err4;
    logic [31:0] err_cnt;
    logic [3:0]  err_cnt4;
    logic [15:0] sticky, sticky4;

    logic [31:0] g [16];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_sticky;

    always #5 clk = ~clk;

    prbs_checker_16lane dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid), .clr(clr),
        .state(state), .locked(locked), .err_word(err_word), .lane_err(lane_err),
        .err_cnt(err_cnt), .lane_err_sticky(sticky)
    );

    prbs_checker_16lane #(.ERR_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid), .clr(clr),
        .state(state4), .locked(locked4), .err_word(err_word4), .lane_err(lane_err4),
        .err_cnt(err_cnt4), .lane_err_sticky(sticky4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive a word (generator output xor flip), then sample 1 time unit after the edge.
    task automatic word(input logic v, input logic [15:0] flip, input logic c);
        logic [15:0] o;
        for (int l = 0; l < 16; l++) o[l] = ^(g[l] & EQN);
        din       = o ^ flip;
        din_valid = v;
        clr       = c;
        @(posedge clk);
        #1;
        if (v) for (int l = 0; l < 16; l++) g[l] = {g[l][30:0], o[l]};
        din_valid = 1'b0;
        clr       = 1'b0;
    endtask

    initial begin
        for (int l = 0; l < 16; l++) g[l] = 32'h0ffd4066 + 32'(l) * 32'h0001_2345;
        rst_n = 1'b0; en = 1'b0; din = '0; din_valid = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_err_word", 32'(err_word), 32'd0);
        chk("reset_lane_err", 32'(lane_err), 32'd0);
        chk("reset_err_cnt", err_cnt, 32'd0);
        chk("reset_sticky", 32'(sticky), 32'd0);
        $display("step reset: state=%0d err_cnt=%0d", state, err_cnt);

        // Lock acquisition
        rst_n = 1'b1; en = 1'b1;
        word(1'b0, 16'h0, 1'b0);
        chk("idle_to_seed", 32'(state), 32'd1);
        for (int i = 0; i < 31; i++) word(1'b1, 16'h0, 1'b0);
        chk("seed_after_31", 32'(state), 32'd1);
        word(1'b1, 16'h0, 1'b0);
        chk("check_after_32", 32'(state), 32'd2);
        for (int i = 0; i < 7; i++) word(1'b1, 16'h0, 1'b0);
        chk("not_locked_39", 32'(locked), 32'd0);
        word(1'b1, 16'h0, 1'b0);
        chk("locked_40", 32'(locked), 32'd1);
        chk("state_locked_40", 32'(state), 32'd3);
        $display("step lock: state=%0d locked=%0d", state, locked);
        for (int i = 0; i < 10000; i++) word(1'b1, 16'h0, 1'b0);
        chk("clean_10k_err_cnt", err_cnt, 32'd0);
        chk("clean_10k_locked", 32'(locked), 32'd1);
        $display("step clean run: err_cnt=%0d locked=%0d", err_cnt, locked);

        // Single error in lane 3
        word(1'b1, 16'h0008, 1'b0);
        chk("single_err_word", 32'(err_word), 32'd1);
        chk("single_lane_err", 32'(lane_err), 32'h0008);
        chk("single_err_cnt", err_cnt, 32'd1);
        chk("single_locked", 32'(locked), 32'd1);
`ifdef PRBS_CHK_LANE_STICKY_EN
        exp_sticky = 16'h0008;
`else
        exp_sticky = 16'h0000;
`endif
        chk("single_sticky", 32'(sticky), 32'(exp_sticky));
        $display("step single error: err_word=%0d lane_err=%h err_cnt=%0d", err_word, lane_err, err_cnt);
        word(1'b1, 16'h0, 1'b0);
        chk("pulse_end_err_word", 32'(err_word), 32'd0);
        chk("pulse_end_lane_err", 32'(lane_err), 32'd0);
        chk("sticky_held", 32'(sticky), 32'(exp_sticky));

        // clr on an idle-valid cycle
        word(1'b0, 16'h0, 1'b1);
        chk("clr_err_cnt", err_cnt, 32'd0);
        chk("clr_sticky", 32'(sticky), 32'd0);
        $display("step clr: err_cnt=%0d sticky=%h", err_cnt, sticky);

        // Loss of lock: 4 inverted words
        word(1'b1, 16'hffff, 1'b0);
        chk("inv1_err_cnt", err_cnt, 32'd16);
        chk("inv1_err_cnt4_sat", 32'(err_cnt4), 32'd15);
        chk("inv1_lane_err", 32'(lane_err), 32'hffff);
        word(1'b1, 16'hffff, 1'b0);
        chk("inv2_err_cnt", err_cnt, 32'd32);
        chk("inv2_err_cnt4_held", 32'(err_cnt4), 32'd15);
        word(1'b1, 16'hffff, 1'b0);
        chk("inv3_still_locked", 32'(state), 32'd3);
        word(1'b1, 16'hffff, 1'b0);
        chk("inv4_err_cnt", err_cnt, 32'd64);
        chk("inv4_state_seed", 32'(state), 32'd1);
        chk("inv4_locked", 32'(locked), 32'd0);
        $display("step loss: err_cnt=%0d err_cnt4=%0d state=%0d", err_cnt, err_cnt4, state);
        for (int i = 0; i < 39; i++) word(1'b1, 16'h0, 1'b0);
        chk("relock_39", 32'(locked), 32'd0);
        word(1'b1, 16'h0, 1'b0);
        chk("relock_40", 32'(locked), 32'd1);
        chk("relock_err_cnt", err_cnt, 32'd64);
        $display("step relock: locked=%0d err_cnt=%0d", locked, err_cnt);

        // clr coincident with an all-lane errored word
        word(1'b1, 16'hffff, 1'b1);
        chk("clr_coinc_err_cnt", err_cnt, 32'd0);
        chk("clr_coinc_err_cnt4", 32'(err_cnt4), 32'd0);
        chk("clr_coinc_sticky", 32'(sticky), 32'd0);
        word(1'b1, 16'h0001, 1'b0);
        chk("after_clr_err_cnt", err_cnt, 32'd1);
        chk("after_clr_err_cnt4", 32'(err_cnt4), 32'd1);
        $display("step clr coincident: err_cnt=%0d err_cnt4=%0d", err_cnt, err_cnt4);

        // en=0 forces IDLE, err_cnt retained
        en = 1'b0;
        word(1'b0, 16'h0, 1'b0);
        chk("en0_state", 32'(state), 32'd0);
        chk("en0_locked", 32'(locked), 32'd0);
        chk("en0_err_cnt_kept", err_cnt, 32'd1);
        $display("step enable off: state=%0d err_cnt=%0d", state, err_cnt);

        // Valid gaps: 1010.. pattern
        en = 1'b1;
        word(1'b0, 16'h0, 1'b0);
        chk("gap_seed", 32'(state), 32'd1);
        for (int i = 0; i < 39; i++) begin
            word(1'b1, 16'h0, 1'b0);
            word(1'b0, 16'h0, 1'b0);
        end
        chk("gap_check_39", 32'(state), 32'd2);
        word(1'b1, 16'h0, 1'b0);
        chk("gap_locked_40", 32'(state), 32'd3);
        word(1'b0, 16'h0, 1'b0);
        chk("gap_err_cnt", err_cnt, 32'd1);
        chk("gap_err_word", 32'(err_word), 32'd0);
        $display("step valid gaps: state=%0d err_cnt=%0d", state, err_cnt);

        // Async reset mid-LOCKED
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_locked", 32'(locked), 32'd0);
        chk("async_err_cnt", err_cnt, 32'd0);
        chk("async_err_cnt4", 32'(err_cnt4), 32'd0);
        chk("async_lane_err", 32'(lane_err), 32'd0);
        $display("step async reset: state=%0d err_cnt=%0d", state, err_cnt);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
